// File: rtl/prng_xoshiro128pp_jump_pkg.sv
// ---------------------------------------------------------------------------
// prng_xoshiro128pp_jump_pkg
//
// Shared constants for the xoshiro128++ generator and its jump engine:
//   - ROT_A/ROT_B/ROT_C : xoshiro128++ rotation/shift amounts (a=7, b=9, c=11),
//                         kept here so checkers can reuse them.
//   - JUMP_C            : jump() polynomial, advances the generator by 2^64.
//   - LONG_JUMP_C       : long_jump() polynomial, advances it by 2^96.
//   - state_t           : jump engine FSM states.
//
// Constant words are stored as packed arrays so that element [0] is the first
// word the C reference walks. Within each word, bits are consumed LSB first.
// ---------------------------------------------------------------------------
package prng_xoshiro128pp_jump_pkg;

  localparam int unsigned ROT_A = 7;
  localparam int unsigned ROT_B = 9;
  localparam int unsigned ROT_C = 11;

  localparam logic [3:0][31:0] JUMP_C = {
    32'h77f2db5b, 32'h6fa035c3, 32'hf542d2d3, 32'h8764000b
  };

  localparam logic [3:0][31:0] LONG_JUMP_C = {
    32'h1c580662, 32'hccf5a0ef, 32'h0b6f099f, 32'hb523952e
  };

  // One STEP cycle per polynomial bit: 4 words x 32 bits.
  localparam logic [6:0] LAST_IDX = 7'd127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    LOAD = 2'd2
  } state_t;

endpackage

// File: rtl/prng_xoshiro128pp_jump.sv
// ---------------------------------------------------------------------------
// prng_xoshiro128pp_jump
//
// Jump engine for xoshiro128++. Sits between the PRNG user and the PRNG's
// seed-control interface. When idle it passes the user's clock-gate and seed
// strobe straight through. On a jump request it takes over the interface:
// for 128 cycles it advances the PRNG once per cycle and XORs the current
// PRNG state into an accumulator whenever the selected polynomial bit is set,
// then writes the accumulator back as the new seed. The cycle after that
// write, o_done pulses and the PRNG holds the jumped state.
//
// Optional feature (macro PRNG_XOSHIRO128PP_LONGJUMP_EN):
//   defined   - i_longJump, sampled with i_jumpReq, selects long_jump();
//   undefined - i_longJump is ignored, only jump() is available.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_jumpReq, i_longJump   jump request (IDLE only) and constant-set select
//   o_busy, o_done          busy from acceptance+1 through LOAD; done pulse
//   i_cg, i_seedValid,
//   i_seedS0..i_seedS3      user-side PRNG controls (passed through in IDLE)
//   i_s0..i_s3              current PRNG state
//   o_prngCg, o_seedValid,
//   o_seedS0..o_seedS3      PRNG-side controls
// ---------------------------------------------------------------------------
module prng_xoshiro128pp_jump
  import prng_xoshiro128pp_jump_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_jumpReq,
  input  logic        i_longJump,
  output logic        o_busy,
  output logic        o_done,
  input  logic        i_cg,
  input  logic        i_seedValid,
  input  logic [31:0] i_seedS0,
  input  logic [31:0] i_seedS1,
  input  logic [31:0] i_seedS2,
  input  logic [31:0] i_seedS3,
  input  logic [31:0] i_s0,
  input  logic [31:0] i_s1,
  input  logic [31:0] i_s2,
  input  logic [31:0] i_s3,
  output logic        o_prngCg,
  output logic        o_seedValid,
  output logic [31:0] o_seedS0,
  output logic [31:0] o_seedS1,
  output logic [31:0] o_seedS2,
  output logic [31:0] o_seedS3
);

  state_t           state_q, state_d;
  logic [3:0][31:0] acc_q, acc_d;
  logic [6:0]       idx_q, idx_d;
  logic             done_q;

  logic [3:0][31:0] prng_state;
  logic [31:0]      const_word;
  logic             jump_bit;
  logic             accept;

  assign prng_state = {i_s3, i_s2, i_s1, i_s0};
  assign accept     = (state_q == IDLE) && i_jumpReq;

  // -------------------------------------------------------------------------
  // Constant-set selection. sel is latched at acceptance so that i_longJump
  // may change freely while the jump is running.
  // -------------------------------------------------------------------------
`ifdef PRNG_XOSHIRO128PP_LONGJUMP_EN
  logic sel_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel_q <= 1'b0;
    end else if (accept) begin
      sel_q <= i_longJump;
    end
  end

  assign const_word = sel_q ? LONG_JUMP_C[idx_q[6:5]] : JUMP_C[idx_q[6:5]];
`else
  logic unused_long_jump;
  assign unused_long_jump = i_longJump;

  assign const_word = JUMP_C[idx_q[6:5]];
`endif

  assign jump_bit = const_word[idx_q[4:0]];

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      // The PRNG loads the accumulator at the end of LOAD, so it holds the
      // jumped state during the following cycle.
      done_q  <= (state_q == LOAD);
    end
  end

  // -------------------------------------------------------------------------
  // Next state and PRNG-side outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    o_prngCg    = i_cg;
    o_seedValid = i_seedValid;
    o_seedS0    = i_seedS0;
    o_seedS1    = i_seedS1;
    o_seedS2    = i_seedS2;
    o_seedS3    = i_seedS3;

    unique case (state_q)
      IDLE: begin
        if (i_jumpReq) begin
          state_d = STEP;
          acc_d   = '0;
          idx_d   = '0;
        end
      end

      STEP: begin
        // User controls are blocked; the PRNG advances exactly once per bit.
        o_prngCg    = 1'b1;
        o_seedValid = 1'b0;
        if (jump_bit) begin
          acc_d = acc_q ^ prng_state;
        end
        // idx wraps 127 -> 0 as the last bit is consumed.
        idx_d = idx_q + 7'd1;
        if (idx_q == LAST_IDX) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        o_prngCg    = 1'b1;
        o_seedValid = 1'b1;
        o_seedS0    = acc_q[0];
        o_seedS1    = acc_q[1];
        o_seedS2    = acc_q[2];
        o_seedS3    = acc_q[3];
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_busy = (state_q != IDLE);
  assign o_done = done_q;

endmodule

// File: tb/tb_prng_xoshiro128pp_jump.sv
// ---------------------------------------------------------------------------
// tb_prng_xoshiro128pp_jump
//
// Bench for the xoshiro128++ jump engine. A behavioural xoshiro128 state
// register stands in for the PRNG and is driven by the engine's PRNG-side
// outputs. Expected jumped states come from a reference jump() written the
// way the C reference is (XOR state into accumulator per set bit, then
// advance), using the bench's own copy of the constants.
// Define PRNG_XOSHIRO128PP_LONGJUMP_EN for both RTL and bench to exercise
// long_jump().
// ---------------------------------------------------------------------------
module tb_prng_xoshiro128pp_jump;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_jumpReq = 1'b0;
  logic        i_longJump = 1'b0;
  logic        o_busy;
  logic        o_done;
  logic        i_cg = 1'b0;
  logic        i_seedValid = 1'b0;
  logic [31:0] i_seedS0 = '0;
  logic [31:0] i_seedS1 = '0;
  logic [31:0] i_seedS2 = '0;
  logic [31:0] i_seedS3 = '0;
  logic        o_prngCg;
  logic        o_seedValid;
  logic [31:0] o_seedS0;
  logic [31:0] o_seedS1;
  logic [31:0] o_seedS2;
  logic [31:0] o_seedS3;

  logic [3:0][31:0] prng_s = '0;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0][31:0] TB_JUMP = {
    32'h77f2db5b, 32'h6fa035c3, 32'hf542d2d3, 32'h8764000b
  };
  localparam logic [3:0][31:0] TB_LONG = {
    32'h1c580662, 32'hccf5a0ef, 32'h0b6f099f, 32'hb523952e
  };

  always #5 i_clk = ~i_clk;

  prng_xoshiro128pp_jump dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_jumpReq   (i_jumpReq),
    .i_longJump  (i_longJump),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .i_cg        (i_cg),
    .i_seedValid (i_seedValid),
    .i_seedS0    (i_seedS0),
    .i_seedS1    (i_seedS1),
    .i_seedS2    (i_seedS2),
    .i_seedS3    (i_seedS3),
    .i_s0        (prng_s[0]),
    .i_s1        (prng_s[1]),
    .i_s2        (prng_s[2]),
    .i_s3        (prng_s[3]),
    .o_prngCg    (o_prngCg),
    .o_seedValid (o_seedValid),
    .o_seedS0    (o_seedS0),
    .o_seedS1    (o_seedS1),
    .o_seedS2    (o_seedS2),
    .o_seedS3    (o_seedS3)
  );

  // xoshiro128 state transition.
  function automatic logic [3:0][31:0] xnext(input logic [3:0][31:0] s_in);
    logic [3:0][31:0] s;
    logic [31:0]      t;
    s    = s_in;
    t    = s[1] << 9;
    s[2] = s[2] ^ s[0];
    s[3] = s[3] ^ s[1];
    s[1] = s[1] ^ s[2];
    s[0] = s[0] ^ s[3];
    s[2] = s[2] ^ t;
    s[3] = {s[3][20:0], s[3][31:21]};
    return s;
  endfunction

  function automatic logic [3:0][31:0] jump_ref(input logic [3:0][31:0] s_in,
                                                input logic [3:0][31:0] k);
    logic [3:0][31:0] s;
    logic [3:0][31:0] acc;
    s   = s_in;
    acc = '0;
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 32; b++) begin
        if (k[w][b]) acc = acc ^ s;
        s = xnext(s);
      end
    end
    return acc;
  endfunction

  function automatic logic [3:0][31:0] mk(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  // Stand-in PRNG: seed load has priority over advance.
  always @(posedge i_clk) begin
    if (o_seedValid) prng_s <= {o_seedS3, o_seedS2, o_seedS1, o_seedS0};
    else if (o_prngCg) prng_s <= xnext(prng_s);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_jumpReq   = 1'b0;
    i_longJump  = 1'b0;
    i_cg        = 1'b0;
    i_seedValid = 1'b0;
    i_seedS0    = '0;
    i_seedS1    = '0;
    i_seedS2    = '0;
    i_seedS3    = '0;
  endtask

  task automatic set_user_seed(input logic [3:0][31:0] s);
    i_seedS0 = s[0];
    i_seedS1 = s[1];
    i_seedS2 = s[2];
    i_seedS3 = s[3];
  endtask

  task automatic load_seed(input logic [3:0][31:0] s);
    @(posedge i_clk); #1;
    i_seedValid = 1'b1;
    set_user_seed(s);
    @(posedge i_clk); #1;
    idle_inputs();
  endtask

  // Runs one jump from acceptance (cycle 0) through the done cycle (130).
  // hold:  user holds every control high (with junk seeds) while busy.
  // rereq: a new request is issued in the done cycle.
  task automatic run_jump(input int id, input logic [3:0][31:0] seed, input logic lj,
                          input logic same_cycle, input logic hold, input logic rereq,
                          input logic [3:0][31:0] expected);
    int done_at;
    int done_cnt;
    int cg_bad;
    int sv_bad;
    int busy_bad;
    logic exp_cg;
    logic exp_sv;
    done_at  = -1;
    done_cnt = 0;
    cg_bad   = 0;
    sv_bad   = 0;
    busy_bad = 0;
    if (!same_cycle) load_seed(seed);
    for (int c = 0; c <= 130; c++) begin
      @(posedge i_clk); #1;
      idle_inputs();
      if (c == 0) begin
        i_jumpReq  = 1'b1;
        i_longJump = lj;
        if (same_cycle) begin
          i_seedValid = 1'b1;
          set_user_seed(seed);
        end
      end else if (c <= 129 && hold) begin
        i_jumpReq   = 1'b1;
        i_longJump  = ~lj;
        i_cg        = 1'b1;
        i_seedValid = 1'b1;
        set_user_seed(mk(32'hffffffff, 32'h12345678, 32'hcafef00d, 32'h0badbeef));
      end else if (c == 130 && rereq) begin
        i_jumpReq = 1'b1;
      end
      @(negedge i_clk);
      exp_cg = (c >= 1 && c <= 129);
      exp_sv = (c == 129) || (c == 0 && same_cycle);
      if (o_prngCg !== exp_cg) cg_bad++;
      if (o_seedValid !== exp_sv) sv_bad++;
      if (o_busy !== exp_cg) busy_bad++;
      if (o_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
    end
    check($sformatf("v%0d done_cycle", id), 128'(done_at), 128'd130);
    check($sformatf("v%0d done_count", id), 128'(done_cnt), 128'd1);
    check($sformatf("v%0d prng_cg_cycles_bad", id), 128'(cg_bad), 128'd0);
    check($sformatf("v%0d seed_valid_cycles_bad", id), 128'(sv_bad), 128'd0);
    check($sformatf("v%0d busy_cycles_bad", id), 128'(busy_bad), 128'd0);
    check($sformatf("v%0d jumped_state", id), prng_s, expected);
    if (!rereq) begin
      @(posedge i_clk); #1;
      idle_inputs();
      @(negedge i_clk);
      check($sformatf("v%0d state_stable_after", id), {o_done, prng_s}, {1'b0, expected});
    end
  endtask

  typedef struct packed {
    logic [3:0][31:0] seed;
    logic             lj;
    logic             same_cycle;
    logic             hold;
    logic [3:0][31:0] expected;
  } vec_t;

  vec_t vecs [5];

  initial begin : main
    logic [3:0][31:0] s1234;
    logic [3:0][31:0] s_alt;
    logic [3:0][31:0] long_k;
    logic [3:0][31:0] exp1;
    int done_at;
    int done_cnt;

    s1234 = mk(32'd1, 32'd2, 32'd3, 32'd4);
    s_alt = mk(32'h9e3779b9, 32'h243f6a88, 32'hb7e15162, 32'h01234567);
`ifdef PRNG_XOSHIRO128PP_LONGJUMP_EN
    long_k = TB_LONG;
`else
    long_k = TB_JUMP;
`endif

    vecs[0] = '{seed: '0,    lj: 1'b0, same_cycle: 1'b0, hold: 1'b0, expected: '0};
    vecs[1] = '{seed: s1234, lj: 1'b0, same_cycle: 1'b0, hold: 1'b0,
                expected: jump_ref(s1234, TB_JUMP)};
    vecs[2] = '{seed: s1234, lj: 1'b1, same_cycle: 1'b0, hold: 1'b0,
                expected: jump_ref(s1234, long_k)};
    vecs[3] = '{seed: s_alt, lj: 1'b0, same_cycle: 1'b1, hold: 1'b0,
                expected: jump_ref(s_alt, TB_JUMP)};
    vecs[4] = '{seed: s_alt, lj: 1'b0, same_cycle: 1'b0, hold: 1'b1,
                expected: jump_ref(s_alt, TB_JUMP)};

    // Reset state and idle passthrough of i_cg.
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("reset busy", 128'(o_busy), 128'd0);
    check("reset done", 128'(o_done), 128'd0);
    check("reset seed_valid passthrough", 128'(o_seedValid), 128'd0);
    @(posedge i_clk); #1;
    i_cg = 1'b1;
    @(negedge i_clk);
    check("reset cg passthrough", 128'(o_prngCg), 128'd1);
    @(posedge i_clk); #1;
    idle_inputs();

    // Idle seed passthrough and advance.
    @(posedge i_clk); #1;
    i_seedValid = 1'b1;
    set_user_seed(mk(32'd5, 32'd6, 32'd7, 32'd8));
    @(negedge i_clk);
    check("pass seed outputs", {o_seedValid, o_prngCg, o_seedS3, o_seedS2, o_seedS1, o_seedS0},
          {1'b1, 1'b0, 32'd8, 32'd7, 32'd6, 32'd5});
    @(posedge i_clk); #1;
    idle_inputs();
    @(negedge i_clk);
    check("pass seed loaded", prng_s, mk(32'd5, 32'd6, 32'd7, 32'd8));
    @(posedge i_clk); #1;
    i_cg = 1'b1;
    @(posedge i_clk); #1;
    i_cg = 1'b0;
    @(negedge i_clk);
    check("pass one advance", prng_s, mk(32'h0000000b, 32'h00000004, 32'h00000c02, 32'h00007000));
    @(posedge i_clk); #1;
    i_cg = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_cg = 1'b0;
    @(negedge i_clk);
    check("pass two advances", prng_s,
          xnext(xnext(mk(32'h0000000b, 32'h00000004, 32'h00000c02, 32'h00007000))));

    // Table-driven jumps.
    for (int i = 0; i < 5; i++) begin
      run_jump(i, vecs[i].seed, vecs[i].lj, vecs[i].same_cycle, vecs[i].hold, 1'b0,
               vecs[i].expected);
    end

    // Reset at cycle 60 of a jump.
    load_seed(s1234);
    @(posedge i_clk); #1;
    i_jumpReq = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge i_clk); #1;
      idle_inputs();
      if (c == 60) i_rst = 1'b1;
    end
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("midreset idle", {o_busy, o_done, o_prngCg}, 3'b000);
    done_cnt = 0;
    for (int c = 0; c < 140; c++) begin
      @(posedge i_clk); #1;
      @(negedge i_clk);
      if (o_done === 1'b1 || o_busy === 1'b1) done_cnt++;
    end
    check("midreset no done/busy after", 128'(done_cnt), 128'd0);
    run_jump(10, s1234, 1'b0, 1'b0, 1'b0, 1'b0, jump_ref(s1234, TB_JUMP));

    // Back-to-back: request in the done cycle.
    exp1 = jump_ref(s_alt, TB_JUMP);
    run_jump(20, s_alt, 1'b0, 1'b0, 1'b0, 1'b1, exp1);
    done_at  = -1;
    done_cnt = 0;
    for (int c = 131; c <= 260; c++) begin
      @(posedge i_clk); #1;
      idle_inputs();
      @(negedge i_clk);
      if (o_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
    end
    check("b2b second done cycle", 128'(done_at), 128'd260);
    check("b2b second done count", 128'(done_cnt), 128'd1);
    check("b2b second state", prng_s, jump_ref(exp1, TB_JUMP));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
